// File: rtl/temp_entry_ctrl.sv
// Signed three-digit BCD temperature entry controller: debounced key, digit FSM, live preview, valid/ready output.
// Optional active-digit blink is enabled by defining TEMP_ENTRY_BLINK_EN.
module temp_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_HALF      = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_n,
  input  logic [3:0]  sw,
  input  logic        sign_sw,
  output logic [3:0]  digit_0,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_value,
  output logic        err
);

  localparam int            DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    NIB_OFF = 4'hA;
  localparam logic [3:0]    NIB_NEG = 4'hB;

  typedef enum logic [1:0] {E_TENTHS, E_UNITS, E_TENS, HOLD} state_t;

  state_t        state;
  logic          key_s1, key_s2, key_db, key_db_q, press;
  logic [DW-1:0] db_cnt;
  logic [3:0]    tenths, units, tens;
  logic          sign;
  logic          digit_ok;
  logic          blink_off;
  logic [3:0]    live;

  assign digit_ok = (sw <= 4'd9);

  // The press pulse lags the debounced fall by one cycle, giving DEBOUNCE_CYCLES+3 total latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      key_s1   <= key_n;
      key_s2   <= key_s1;
      key_db_q <= key_db;
      press    <= key_db_q & ~key_db;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= E_TENTHS;
      tenths    <= '0;
      units     <= '0;
      tens      <= '0;
      sign      <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        E_TENTHS: if (press) begin
          if (digit_ok) begin
            tenths <= sw;
            state  <= E_UNITS;
          end else begin
            err <= 1'b1;
          end
        end
        E_UNITS: if (press) begin
          if (digit_ok) begin
            units <= sw;
            state <= E_TENS;
          end else begin
            err <= 1'b1;
          end
        end
        E_TENS: if (press) begin
          if (digit_ok) begin
            tens      <= sw;
            sign      <= sign_sw;
            state     <= HOLD;
            out_valid <= 1'b1;
            out_value <= {sign_sw, sw, units, tenths};
          end else begin
            err <= 1'b1;
          end
        end
        HOLD: if (out_valid && out_ready) begin
          state     <= E_TENTHS;
          tenths    <= '0;
          units     <= '0;
          tens      <= '0;
          sign      <= 1'b0;
          out_valid <= 1'b0;
          out_value <= '0;
        end
        default: state <= E_TENTHS;
      endcase
    end
  end

`ifdef TEMP_ENTRY_BLINK_EN
  localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  // Without blinking the phase stays "on"; BLINK_HALF is legal only when >= 1.
  assign blink_off = (BLINK_HALF < 1);
`endif

  assign live = (digit_ok && !blink_off) ? sw : NIB_OFF;

  always_comb begin
    digit_0 = tenths;
    digit_1 = units;
    digit_2 = tens;
    digit_3 = sign ? NIB_NEG : NIB_OFF;
    case (state)
      E_TENTHS: begin
        digit_0 = live;
        digit_1 = NIB_OFF;
        digit_2 = NIB_OFF;
        digit_3 = NIB_OFF;
      end
      E_UNITS: begin
        digit_1 = live;
        digit_2 = NIB_OFF;
        digit_3 = NIB_OFF;
      end
      E_TENS: begin
        digit_2 = live;
        digit_3 = sign_sw ? NIB_NEG : NIB_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_temp_entry_ctrl.sv
// Testbench for temp_entry_ctrl: directed entry/handshake/debounce cases plus random presses vs a digit-level model.
module tb_temp_entry_ctrl;

  localparam int D  = 4;
  localparam int BH = 8;

  logic        clk = 1'b0;
  logic        rst, key_n, sign_sw, out_ready;
  logic [3:0]  sw;
  logic [3:0]  digit_0, digit_1, digit_2, digit_3;
  logic        out_valid, err;
  logic [12:0] out_value;

  int checks = 0;
  int passed = 0;
  int errCount = 0;

  int         mState = 0;
  logic [3:0] mDig [3] = '{4'd0, 4'd0, 4'd0};
  logic       mSign = 1'b0;
  logic       mValid = 1'b0;
  logic       mErr = 1'b0;
  int         pend = 0;
`ifdef TEMP_ENTRY_BLINK_EN
  int         sinceRst = 0;
`endif

  temp_entry_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .sw(sw), .sign_sw(sign_sw),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Digits before the entry position are stored, the one at it is live, later ones are blank.
  function automatic logic [3:0] expDigit(input int i);
    logic [3:0] live;
    live = (sw <= 4'd9) ? sw : 4'hA;
`ifdef TEMP_ENTRY_BLINK_EN
    if (((sinceRst / BH) % 2) == 1) live = 4'hA;
`endif
    if (i < mState) return mDig[i];
    if (i == mState) return live;
    return 4'hA;
  endfunction

  function automatic logic [3:0] expSign();
    if (mState == 2) return sign_sw ? 4'hB : 4'hA;
    if (mState == 3) return mSign ? 4'hB : 4'hA;
    return 4'hA;
  endfunction

  task automatic modelEdge();
    logic pressNow;
    pressNow = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) pressNow = 1'b1;
    end
    mErr = 1'b0;
    if (rst) begin
      mState = 0;
      mDig   = '{4'd0, 4'd0, 4'd0};
      mSign  = 1'b0;
      mValid = 1'b0;
      pend   = 0;
`ifdef TEMP_ENTRY_BLINK_EN
      sinceRst = 0;
`endif
    end else begin
`ifdef TEMP_ENTRY_BLINK_EN
      sinceRst++;
`endif
      if (mState == 3) begin
        if (out_ready) begin
          mState = 0;
          mDig   = '{4'd0, 4'd0, 4'd0};
          mSign  = 1'b0;
          mValid = 1'b0;
        end
      end else if (pressNow) begin
        if (sw <= 4'd9) begin
          mDig[mState] = sw;
          if (mState == 2) mSign = sign_sw;
          mState++;
          if (mState == 3) mValid = 1'b1;
        end else begin
          mErr = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    if (err === 1'b1) errCount++;
    checkOutput("digit_0", 16'(digit_0), 16'(expDigit(0)));
    checkOutput("digit_1", 16'(digit_1), 16'(expDigit(1)));
    checkOutput("digit_2", 16'(digit_2), 16'(expDigit(2)));
    checkOutput("digit_3", 16'(digit_3), 16'(expSign()));
    checkOutput("out_valid", 16'(out_valid), 16'(mValid));
    checkOutput("out_value", 16'(out_value),
                mValid ? 16'({mSign, mDig[2], mDig[1], mDig[0]}) : 16'h0);
    checkOutput("err", 16'(err), 16'(mErr));
  endtask

  // Hold the key low for lowCycles samples, then high long enough for the release to settle.
  task automatic applyStimulus(input logic [3:0] s, input logic sg, input int lowCycles, input logic rdy);
    sw        = s;
    sign_sw   = sg;
    out_ready = rdy;
    key_n     = 1'b0;
    if (lowCycles >= D) pend = D + 4;
    repeat (lowCycles) tick();
    key_n = 1'b1;
    repeat (D + 4) tick();
  endtask

  initial begin
    int errBefore;
    rst = 1'b1; key_n = 1'b1; sw = 4'd7; sign_sw = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_digit_0", 16'(digit_0), 16'h7);
    checkOutput("rst_digit_1", 16'(digit_1), 16'hA);
    checkOutput("rst_digit_2", 16'(digit_2), 16'hA);
    checkOutput("rst_digit_3", 16'(digit_3), 16'hA);
    checkOutput("rst_out_valid", 16'(out_valid), 16'h0);

    applyStimulus(4'd5, 1'b0, 6, 1'b0);
    applyStimulus(4'd2, 1'b0, 6, 1'b0);
    applyStimulus(4'd1, 1'b1, 6, 1'b0);
    checkOutput("entry_valid", 16'(out_valid), 16'h1);
    checkOutput("entry_value", 16'(out_value), 16'h1125);
    checkOutput("entry_sign", 16'(digit_3), 16'hB);

    errBefore = errCount;
    applyStimulus(4'd3, 1'b0, 6, 1'b0);
    applyStimulus(4'hC, 1'b0, 6, 1'b0);
    checkOutput("hold_no_err", 16'(errCount - errBefore), 16'h0);
    checkOutput("hold_value", 16'(out_value), 16'h1125);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("hs_valid", 16'(out_valid), 16'h0);
    checkOutput("hs_digit_1", 16'(digit_1), 16'hA);

    applyStimulus(4'd5, 1'b0, 6, 1'b0);
    errBefore = errCount;
    applyStimulus(4'hC, 1'b0, 6, 1'b0);
    checkOutput("bad_err_cycles", 16'(errCount - errBefore), 16'h1);
    checkOutput("bad_digit_1", 16'(digit_1), 16'hA);
    applyStimulus(4'd3, 1'b0, 6, 1'b0);
    checkOutput("units_stored", 16'(digit_1), 16'h3);

    applyStimulus(4'd7, 1'b0, D - 1, 1'b0);
    applyStimulus(4'd7, 1'b0, D - 1, 1'b0);
    checkOutput("glitch_valid", 16'(out_valid), 16'h0);
    applyStimulus(4'd4, 1'b1, 10, 1'b0);
    checkOutput("long_value", 16'(out_value), 16'h1435);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    applyStimulus(4'd1, 1'b0, 6, 1'b0);
    applyStimulus(4'd2, 1'b0, 6, 1'b0);
    sw = 4'd6;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_digit_0", 16'(digit_0), 16'h6);
    checkOutput("mid_rst_digit_1", 16'(digit_1), 16'hA);
    checkOutput("mid_rst_digit_2", 16'(digit_2), 16'hA);
    checkOutput("mid_rst_valid", 16'(out_valid), 16'h0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] s;
      int         low;
      s   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      low = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, D - 1)) : int'($urandom_range(D, D + 6));
      applyStimulus(s, 1'($urandom_range(0, 1)), low, 1'($urandom_range(0, 2) == 0));
    end
    out_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
